ysyx_mem_arb: RTL and testbench

YSYX_MEM_ARB -- requirements
Module: ysyx_mem_arb

---
 rtl/ysyx_mem_arb_if.sv | 56 +++++
 rtl/ysyx_mem_arb.sv | 154 +++++++++++++++
 tb/tb_ysyx_mem_arb.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_mem_arb_if.sv
// Bundles the IFU, LSU and downstream memory signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

interface ysyx_mem_arb_if #(
  parameter int unsigned XLEN = `YSYX_XLEN
);
  logic            ifu_arvalid;
  logic [XLEN-1:0] ifu_araddr;
  logic            ifu_bus_ready;
  logic            ifu_rready;
  logic [XLEN-1:0] ifu_rdata;

  logic            lsu_arvalid;
  logic [XLEN-1:0] lsu_araddr;
  logic [7:0]      lsu_rstrb;
  logic            lsu_rvalid;
  logic [XLEN-1:0] lsu_rdata;
  logic            lsu_awvalid;
  logic            lsu_wvalid;
  logic [XLEN-1:0] lsu_awaddr;
  logic [XLEN-1:0] lsu_wdata;
  logic [7:0]      lsu_wstrb;
  logic            lsu_wready;

  logic            mem_valid;
  logic            mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_strb;
  logic            mem_ready;
  logic            mem_resp;
  logic [XLEN-1:0] mem_rdata;

  modport slave (
    input  ifu_arvalid, ifu_araddr,
    input  lsu_arvalid, lsu_araddr, lsu_rstrb,
    input  lsu_awvalid, lsu_wvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    input  mem_ready, mem_resp, mem_rdata,
    output ifu_bus_ready, ifu_rready, ifu_rdata,
    output lsu_rvalid, lsu_rdata, lsu_wready,
    output mem_valid, mem_wen, mem_addr, mem_wdata, mem_strb
  );

  modport master (
    output ifu_arvalid, ifu_araddr,
    output lsu_arvalid, lsu_araddr, lsu_rstrb,
    output lsu_awvalid, lsu_wvalid, lsu_awaddr, lsu_wdata, lsu_wstrb,
    output mem_ready, mem_resp, mem_rdata,
    input  ifu_bus_ready, ifu_rready, ifu_rdata,
    input  lsu_rvalid, lsu_rdata, lsu_wready,
    input  mem_valid, mem_wen, mem_addr, mem_wdata, mem_strb
  );
endinterface

// File: rtl/ysyx_mem_arb.sv
// Single-outstanding memory arbiter between IFU fetches and LSU loads/stores,
// with a starvation counter that forces an IFU grant after STARVE_MAX LSU wins.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_mem_arb #(
  parameter int unsigned XLEN       = `YSYX_XLEN,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic           clock,
  input logic           reset,
  ysyx_mem_arb_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StIfuReq,
    StLsuRdReq,
    StLsuWrReq,
    StWaitResp
  } state_e;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIfu,
    OwnLoad,
    OwnStore
  } owner_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [7:0]      strb_q, strb_d;
  logic            wen_q, wen_d;
  logic [3:0]      starve_cnt_q, starve_cnt_d;

  logic store_req, load_req, ifu_req, ifu_starved, grant_ifu;
  logic [3:0] starve_inc;

  assign store_req   = bus.lsu_awvalid & bus.lsu_wvalid;
  assign load_req    = bus.lsu_arvalid;
  assign ifu_req     = bus.ifu_arvalid;
  assign ifu_starved = ifu_req && (starve_cnt_q == StarveMax);
  assign grant_ifu   = ifu_req & (ifu_starved | ~(store_req | load_req));
  // Only LSU grants that overtake a waiting IFU count towards starvation.
  assign starve_inc  = (ifu_req && starve_cnt_q != StarveMax) ? starve_cnt_q + 4'd1
                                                             : starve_cnt_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    wen_d        = wen_q;
    starve_cnt_d = starve_cnt_q;

    bus.ifu_bus_ready = 1'b0;
    bus.ifu_rready    = 1'b0;
    bus.ifu_rdata     = '0;
    bus.lsu_rvalid    = 1'b0;
    bus.lsu_rdata     = '0;
    bus.lsu_wready    = 1'b0;
    bus.mem_valid     = 1'b0;
    bus.mem_wen       = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_strb      = '0;

    unique case (state_q)
      StIdle: begin
        bus.ifu_bus_ready = 1'b1;
        if (grant_ifu) begin
          state_d      = StIfuReq;
          owner_d      = OwnIfu;
          addr_d       = bus.ifu_araddr;
          wdata_d      = '0;
          strb_d       = 8'hFF;
          wen_d        = 1'b0;
          starve_cnt_d = 4'd0;
        end else if (store_req) begin
          state_d      = StLsuWrReq;
          owner_d      = OwnStore;
          addr_d       = bus.lsu_awaddr;
          wdata_d      = bus.lsu_wdata;
          strb_d       = bus.lsu_wstrb;
          wen_d        = 1'b1;
          starve_cnt_d = starve_inc;
        end else if (load_req) begin
          state_d      = StLsuRdReq;
          owner_d      = OwnLoad;
          addr_d       = bus.lsu_araddr;
          wdata_d      = '0;
          strb_d       = bus.lsu_rstrb;
          wen_d        = 1'b0;
          starve_cnt_d = starve_inc;
        end
      end
      StIfuReq, StLsuRdReq, StLsuWrReq: begin
        bus.mem_valid = 1'b1;
        bus.mem_wen   = wen_q;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_strb  = strb_q;
        if (bus.mem_ready) begin
          state_d = StWaitResp;
        end
      end
      StWaitResp: begin
        if (bus.mem_resp) begin
          state_d = StIdle;
          unique case (owner_q)
            OwnIfu: begin
              bus.ifu_rready = 1'b1;
              bus.ifu_rdata  = bus.mem_rdata;
            end
            OwnLoad: begin
              bus.lsu_rvalid = 1'b1;
              bus.lsu_rdata  = bus.mem_rdata;
            end
            OwnStore: bus.lsu_wready = 1'b1;
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnNone;
      addr_q       <= '0;
      wdata_q      <= '0;
      strb_q       <= '0;
      wen_q        <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      wen_q        <= wen_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_mem_arb.sv
// Directed bench for ysyx_mem_arb: inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_ysyx_mem_arb;

  localparam int unsigned XLEN = 32;
  localparam int Ifu = 0;
  localparam int Load = 1;
  localparam int Store = 2;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ysyx_mem_arb_if #(.XLEN(XLEN)) bus ();

  ysyx_mem_arb #(
    .XLEN       (XLEN),
    .STARVE_MAX (4)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.ifu_arvalid = 1'b0;
    bus.ifu_araddr  = '0;
    bus.lsu_arvalid = 1'b0;
    bus.lsu_araddr  = '0;
    bus.lsu_rstrb   = '0;
    bus.lsu_awvalid = 1'b0;
    bus.lsu_wvalid  = 1'b0;
    bus.lsu_awaddr  = '0;
    bus.lsu_wdata   = '0;
    bus.lsu_wstrb   = '0;
    bus.mem_ready   = 1'b0;
    bus.mem_resp    = 1'b0;
    bus.mem_rdata   = '0;
  endtask

  // Entered just after the grant edge; runs the request phase (with `stall`
  // cycles of backpressure) and the response phase, returning in IDLE.
  task automatic service(input int stall, input int who, input logic [31:0] addr,
                         input logic [7:0] strb, input logic [31:0] wdata,
                         input logic [31:0] rdata);
    for (int i = 0; i < stall; i++) begin
      @(negedge clock);
      bus.mem_ready = 1'b0;
      bus.mem_resp  = (i == 0);  // stray response must be ignored
      #1;
      check("stall_valid", bus.mem_valid, 1);
      check("stall_addr", bus.mem_addr, addr);
      check("stall_strb", bus.mem_strb, strb);
      check("stall_no_rvalid", bus.lsu_rvalid | bus.ifu_rready | bus.lsu_wready, 0);
    end
    @(negedge clock);
    bus.mem_resp  = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("req_valid", bus.mem_valid, 1);
    check("req_addr", bus.mem_addr, addr);
    check("req_strb", bus.mem_strb, strb);
    check("req_wen", bus.mem_wen, (who == Store));
    check("req_wdata", bus.mem_wdata, wdata);
    check("req_bus_ready", bus.ifu_bus_ready, 0);
    @(negedge clock);
    bus.mem_ready = 1'b0;
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    check("resp_valid_low", bus.mem_valid, 0);
    check("resp_ifu_rready", bus.ifu_rready, (who == Ifu));
    check("resp_lsu_rvalid", bus.lsu_rvalid, (who == Load));
    check("resp_lsu_wready", bus.lsu_wready, (who == Store));
    if (who == Ifu) check("resp_ifu_rdata", bus.ifu_rdata, rdata);
    if (who == Load) check("resp_lsu_rdata", bus.lsu_rdata, rdata);
    @(posedge clock);
    #1;
    bus.mem_resp = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_bus_ready", bus.ifu_bus_ready, 1);
    check("rst_mem_valid", bus.mem_valid, 0);
    check("rst_mem_wen", bus.mem_wen, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_mem_strb", bus.mem_strb, 0);
    check("rst_pulses", {bus.ifu_rready, bus.lsu_rvalid, bus.lsu_wready}, 0);
    reset = 1'b1;

    // IFU fetch alone
    @(negedge clock);
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr  = 32'h8000_0000;
    #1;
    check("ifu_idle_ready", bus.ifu_bus_ready, 1);
    @(posedge clock);
    #1;
    bus.ifu_arvalid = 1'b0;
    service(0, Ifu, 32'h8000_0000, 8'hFF, 32'h0, 32'h0000_0413);
    check("ifu_back_idle", bus.ifu_bus_ready, 1);

    // Store beats IFU, then IFU wins the next IDLE
    @(negedge clock);
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr  = 32'h8000_0004;
    bus.lsu_awvalid = 1'b1;
    bus.lsu_wvalid  = 1'b1;
    bus.lsu_awaddr  = 32'h8000_1000;
    bus.lsu_wdata   = 32'hDEAD_BEEF;
    bus.lsu_wstrb   = 8'h0F;
    @(posedge clock);
    #1;
    bus.lsu_awvalid = 1'b0;
    bus.lsu_wvalid  = 1'b0;
    check("store_starve_cnt", dut.starve_cnt_q, 1);
    service(0, Store, 32'h8000_1000, 8'h0F, 32'hDEAD_BEEF, 32'h0);
    @(posedge clock);
    #1;
    bus.ifu_arvalid = 1'b0;
    check("ifu_after_store_cnt", dut.starve_cnt_q, 0);
    service(0, Ifu, 32'h8000_0004, 8'hFF, 32'h0, 32'h0000_0013);

    // Starvation: four loads overtake a waiting IFU, then IFU is forced
    @(negedge clock);
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr  = 32'h8000_0008;
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr  = 32'h8000_2000;
    bus.lsu_rstrb   = 8'h03;
    for (int g = 0; g < 5; g++) begin
      @(posedge clock);
      #1;
      if (g < 4) begin
        check("starve_cnt_lsu", dut.starve_cnt_q, g + 1);
        service(0, Load, 32'h8000_2000, 8'h03, 32'h0, 32'h1111_0000 + g);
      end else begin
        check("starve_cnt_ifu", dut.starve_cnt_q, 0);
        bus.ifu_arvalid = 1'b0;
        bus.lsu_arvalid = 1'b0;
        service(0, Ifu, 32'h8000_0008, 8'hFF, 32'h0, 32'h2222_0000);
      end
    end

    // Backpressure on a load
    @(negedge clock);
    bus.lsu_arvalid = 1'b1;
    bus.lsu_araddr  = 32'h8000_3000;
    bus.lsu_rstrb   = 8'hF0;
    @(posedge clock);
    #1;
    bus.lsu_arvalid = 1'b0;
    service(5, Load, 32'h8000_3000, 8'hF0, 32'h0, 32'h1234_5678);

    // Reset while waiting for a response; the late response is dropped
    @(negedge clock);
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr  = 32'h8000_0010;
    @(negedge clock);
    bus.ifu_arvalid = 1'b0;
    bus.mem_ready   = 1'b1;
    @(negedge clock);
    bus.mem_ready = 1'b0;
    check("pre_reset_waiting", bus.ifu_bus_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("post_reset_ready", bus.ifu_bus_ready, 1);
    check("post_reset_valid", bus.mem_valid, 0);
    @(negedge clock);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    #1;
    check("late_resp_pulses", {bus.ifu_rready, bus.lsu_rvalid, bus.lsu_wready}, 0);
    check("late_resp_idle", bus.ifu_bus_ready, 1);
    @(negedge clock);
    bus.mem_resp = 1'b0;

    // Half-valid store does not arbitrate; IFU goes first
    bus.lsu_awvalid = 1'b1;
    bus.lsu_wvalid  = 1'b0;
    bus.lsu_awaddr  = 32'h8000_4000;
    bus.lsu_wdata   = 32'h0BAD_F00D;
    bus.lsu_wstrb   = 8'h3C;
    bus.ifu_arvalid = 1'b1;
    bus.ifu_araddr  = 32'h8000_0020;
    @(posedge clock);
    #1;
    bus.ifu_arvalid = 1'b0;
    service(0, Ifu, 32'h8000_0020, 8'hFF, 32'h0, 32'h0000_0073);
    repeat (2) begin
      @(negedge clock);
      #1;
      check("half_store_held", bus.ifu_bus_ready, 1);
      check("half_store_no_valid", bus.mem_valid, 0);
    end
    bus.lsu_wvalid = 1'b1;
    @(posedge clock);
    #1;
    bus.lsu_awvalid = 1'b0;
    bus.lsu_wvalid  = 1'b0;
    service(0, Store, 32'h8000_4000, 8'h3C, 32'h0BAD_F00D, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
